// File: rtl/ffdiv_pkg.sv
// Shared types and constants for the ffdiv request dispatcher.
// Defines operand/flag widths, the FSM state encoding and the queued request layout.
package ffdiv_pkg;

  localparam int OPERAND_WIDTH = 32;
  localparam int FLAG_SIZE     = 5;
  localparam int TAG_WIDTH     = 4;
  localparam int ITR_WIDTH     = $clog2(OPERAND_WIDTH);

  // Divider flag bit positions: {NaNF, OVF, INF, UF, ZF}
  localparam int NANF = 4;
  localparam int OVF  = 3;
  localparam int INF  = 2;
  localparam int UF   = 1;
  localparam int ZF   = 0;

  localparam logic [OPERAND_WIDTH-1:0] QNAN         = 32'h7FC0_0000;
  localparam logic [FLAG_SIZE-1:0]     TIMEOUT_FLAG = FLAG_SIZE'(1 << NANF);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RDY = 2'd2,
    DRAIN    = 2'd3
  } dispatch_state_e;

  typedef struct packed {
    logic [OPERAND_WIDTH-1:0] op1;
    logic [OPERAND_WIDTH-1:0] op2;
    logic [TAG_WIDTH-1:0]     tag;
  } req_entry_t;

  // Debug view: FSM state plus the iteration count sampled with the last result.
  typedef struct packed {
    dispatch_state_e          state;
    logic [ITR_WIDTH-1:0]     itr_count;
  } dispatch_dbg_t;

endpackage

// File: rtl/ffdiv_req_fifo.sv
// Synchronous request FIFO of req_entry_t; pointers wrap modulo DEPTH (power of two).
// Push is ignored when full and pop when empty; simultaneous push and pop are allowed.
module ffdiv_req_fifo
  import ffdiv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  req_entry_t               push_data,
  input  logic                     pop,
  output req_entry_t               pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

  req_entry_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ffdiv_dispatch.sv
// Dispatcher in front of ffdiv_top: queues requests, issues one at a time, captures the
// divider result (or a timeout NaN) onto a valid/ready response port and keeps statistics.
module ffdiv_dispatch
  import ffdiv_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LAT_WIDTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // Request port: a request transfers on a rising edge where req_valid & req_ready.
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [OPERAND_WIDTH-1:0]  req_op1,
  input  logic [OPERAND_WIDTH-1:0]  req_op2,
  input  logic [TAG_WIDTH-1:0]      req_tag,
  output logic                      div_en,
  output logic [OPERAND_WIDTH-1:0]  div_operand1,
  output logic [OPERAND_WIDTH-1:0]  div_operand2,
  input  logic                      div_ready,
  input  logic [OPERAND_WIDTH-1:0]  div_result,
  input  logic [FLAG_SIZE-1:0]      div_flag,
  input  logic [ITR_WIDTH-1:0]      div_itr_count,
  // Response port: a response transfers on a rising edge where rsp_valid & rsp_ready;
  // rsp_* hold steady while rsp_valid & ~rsp_ready.
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [OPERAND_WIDTH-1:0]  rsp_result,
  output logic [FLAG_SIZE-1:0]      rsp_flag,
  output logic [TAG_WIDTH-1:0]      rsp_tag,
  output logic [LAT_WIDTH-1:0]      rsp_latency,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic [31:0]               stat_count,
  output logic [31:0]               stat_lat_sum,
  output dispatch_dbg_t             dbg
);

  localparam logic [LAT_WIDTH-1:0] LAT_MAX   = '1;
  localparam logic [LAT_WIDTH-1:0] TIMEOUT_L = LAT_WIDTH'(TIMEOUT);

  dispatch_state_e           state;
  dispatch_state_e           state_next;
  logic                      pop;
  logic                      capture;
  logic                      expire;

  req_entry_t                push_entry;
  req_entry_t                head;
  logic [$clog2(DEPTH):0]    fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;

  logic [TAG_WIDTH-1:0]      cur_tag;
  logic [LAT_WIDTH-1:0]      lat_cnt;
  logic [LAT_WIDTH-1:0]      done_lat;
  logic [ITR_WIDTH-1:0]      itr_q;

  assign push_entry = '{op1: req_op1, op2: req_op2, tag: req_tag};

  ffdiv_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_valid & req_ready),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // req_ready comes from the registered count only, so a full FIFO never accepts
  // even when a pop happens in the same cycle.
  assign req_ready = ~fifo_full;
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign div_en    = (state == ISSUE) || (state == WAIT_RDY);

  assign dbg.state     = state;
  assign dbg.itr_count = itr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        // A still-high ready from the previous op must drop before a new issue.
        if (!fifo_empty && !rsp_valid && !div_ready) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (div_ready) begin
          capture    = 1'b1;
          state_next = DRAIN;
        end else if (lat_cnt >= TIMEOUT_L) begin
          expire     = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!div_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign done_lat = capture ? lat_cnt : TIMEOUT_L;

  // Operands and tag load on the pop edge so they are valid for the whole ISSUE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_operand1 <= '0;
      div_operand2 <= '0;
      cur_tag      <= '0;
      lat_cnt      <= '0;
    end else if (pop) begin
      div_operand1 <= head.op1;
      div_operand2 <= head.op2;
      cur_tag      <= head.tag;
      lat_cnt      <= LAT_WIDTH'(1);
    end else if (div_en && (lat_cnt != LAT_MAX)) begin
      lat_cnt      <= lat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_flag     <= '0;
      rsp_tag      <= '0;
      rsp_latency  <= '0;
      rsp_timeout  <= 1'b0;
      stat_count   <= '0;
      stat_lat_sum <= '0;
      itr_q        <= '0;
    end else if (capture || expire) begin
      rsp_valid    <= 1'b1;
      rsp_result   <= capture ? div_result : QNAN;
      rsp_flag     <= capture ? div_flag : TIMEOUT_FLAG;
      rsp_tag      <= cur_tag;
      rsp_latency  <= done_lat;
      rsp_timeout  <= expire;
      stat_count   <= stat_count + 32'd1;
      stat_lat_sum <= stat_lat_sum + 32'(done_lat);
      itr_q        <= capture ? div_itr_count : '0;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ffdiv_dispatch.sv
// Directed bench for ffdiv_dispatch with a small behavioural divider driven from tasks.
// Each scenario task checks its own expectations inline and steps total/bad.
module tb_ffdiv_dispatch;
  import ffdiv_pkg::*;

  logic                      clk;
  logic                      rst_n;
  logic                      req_valid;
  logic                      req_ready;
  logic [OPERAND_WIDTH-1:0]  req_op1;
  logic [OPERAND_WIDTH-1:0]  req_op2;
  logic [TAG_WIDTH-1:0]      req_tag;
  logic                      div_en;
  logic [OPERAND_WIDTH-1:0]  div_operand1;
  logic [OPERAND_WIDTH-1:0]  div_operand2;
  logic                      div_ready;
  logic [OPERAND_WIDTH-1:0]  div_result;
  logic [FLAG_SIZE-1:0]      div_flag;
  logic [ITR_WIDTH-1:0]      div_itr_count;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [OPERAND_WIDTH-1:0]  rsp_result;
  logic [FLAG_SIZE-1:0]      rsp_flag;
  logic [TAG_WIDTH-1:0]      rsp_tag;
  logic [7:0]                rsp_latency;
  logic                      rsp_timeout;
  logic                      busy;
  logic [31:0]               stat_count;
  logic [31:0]               stat_lat_sum;
  dispatch_dbg_t             dbg;

  int total;
  int bad;

  ffdiv_dispatch #(
    .DEPTH     (4),
    .LAT_WIDTH (8),
    .TIMEOUT   (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .req_tag       (req_tag),
    .div_en        (div_en),
    .div_operand1  (div_operand1),
    .div_operand2  (div_operand2),
    .div_ready     (div_ready),
    .div_result    (div_result),
    .div_flag      (div_flag),
    .div_itr_count (div_itr_count),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_flag      (rsp_flag),
    .rsp_tag       (rsp_tag),
    .rsp_latency   (rsp_latency),
    .rsp_timeout   (rsp_timeout),
    .busy          (busy),
    .stat_count    (stat_count),
    .stat_lat_sum  (stat_lat_sum),
    .dbg           (dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic push_req(input logic [31:0] op1, input logic [31:0] op2, input logic [3:0] tag);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op1   = op1;
    req_op2   = op2;
    req_tag   = tag;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Divider model: waits for div_en, then raises div_ready in the lat-th div_en cycle
  // (so the dispatcher measures lat) and holds it for 'hold' cycles.
  task automatic run_op(input int lat, input int hold, input logic [31:0] res,
                        input logic [4:0] flg, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (div_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      repeat (lat - 1) @(posedge clk);
      #1;
      div_ready     = 1'b1;
      div_result    = res;
      div_flag      = flg;
      div_itr_count = 5'd24;
      repeat (hold) @(posedge clk);
      #1;
      div_ready     = 1'b0;
    end
  endtask

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    total++;
    if (div_en !== 1'b0) begin bad++; $display("FAIL reset_div_en: got %b want 0", div_en); end
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if ({stat_count, stat_lat_sum} !== 64'd0) begin
      bad++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_count, stat_lat_sum);
    end
    total++;
    if ({div_operand1, rsp_result, rsp_latency} !== '0) begin
      bad++; $display("FAIL reset_data: got op1=%h res=%h lat=%0d want 0", div_operand1, rsp_result, rsp_latency);
    end
  endtask

  task automatic test_single_op();
    bit ok;
    push_req(32'h4120_0000, 32'h4000_0000, 4'd3);
    run_op(10, 1, 32'h40A0_0000, 5'b00000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_issue: got no div_en want div_en"); end
    total++;
    if ({div_operand1, div_operand2} !== {32'h4120_0000, 32'h4000_0000}) begin
      bad++; $display("FAIL single_operands: got %h/%h want 41200000/40000000", div_operand1, div_operand2);
    end
    wait_rsp(50, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_rsp_wait: got no rsp_valid want rsp_valid"); end
    total++;
    if (rsp_result !== 32'h40A0_0000) begin bad++; $display("FAIL single_result: got %h want 40a00000", rsp_result); end
    total++;
    if (rsp_tag !== 4'd3) begin bad++; $display("FAIL single_tag: got %0d want 3", rsp_tag); end
    total++;
    if (rsp_latency !== 8'd10) begin bad++; $display("FAIL single_latency: got %0d want 10", rsp_latency); end
    total++;
    if ({rsp_flag, rsp_timeout, div_en} !== 7'b0) begin
      bad++; $display("FAIL single_flags: got flag=%b to=%b en=%b want 0/0/0", rsp_flag, rsp_timeout, div_en);
    end
    total++;
    if (stat_count !== 32'd1 || stat_lat_sum !== 32'd10) begin
      bad++; $display("FAIL single_stats: got %0d/%0d want 1/10", stat_count, stat_lat_sum);
    end
    accept_rsp();
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_clear: got %b want 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int en_seen;
    @(posedge clk);
    #1;
    div_ready = 1'b1;  // a held-high ready blocks any issue, so the FIFO fills
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_tag   = 4'(i);
      req_op1   = 32'h3F80_0000 + 32'(i);
      req_op2   = 32'h3F80_0000;
      @(negedge clk);
      total++;
      if (req_ready !== (i < 4)) begin bad++; $display("FAIL bp_req_ready_%0d: got %b want %b", i, req_ready, i < 4); end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    div_ready = 1'b0;
    for (int t = 0; t < 4; t++) begin
      run_op(3, 1, 32'h4000_0000 + 32'(t), 5'b0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL bp_issue_%0d: got no div_en want div_en", t); end
      wait_rsp(50, ok);
      total++;
      if (!ok || rsp_tag !== 4'(t) || rsp_result !== 32'h4000_0000 + 32'(t)) begin
        bad++; $display("FAIL bp_order_%0d: got valid=%b tag=%0d res=%h want tag %0d", t, rsp_valid, rsp_tag, rsp_result, t);
      end
      if (t == 0) begin
        en_seen = 0;
        repeat (20) begin
          @(negedge clk);
          if (div_en === 1'b1) en_seen++;
        end
        total++;
        if (en_seen != 0 || rsp_valid !== 1'b1 || rsp_tag !== 4'd0) begin
          bad++; $display("FAIL bp_hold: got en_cycles=%0d valid=%b tag=%0d want 0/1/0", en_seen, rsp_valid, rsp_tag);
        end
      end
      accept_rsp();
    end
    @(negedge clk);
    total++;
    if (stat_count !== 32'd5 || stat_lat_sum !== 32'd22) begin
      bad++; $display("FAIL bp_stats: got %0d/%0d want 5/22", stat_count, stat_lat_sum);
    end
  endtask

  task automatic test_sticky_ready();
    bit ok1;
    bit ok2;
    int hs;
    int en_rdy;
    int rises;
    int last_rdy;
    int second_rise;
    logic prev_en;
    hs = 0; en_rdy = 0; rises = 0; last_rdy = -1; second_rise = -1; prev_en = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    div_ready = 1'b1;
    push_req(32'h4100_0000, 32'h4000_0000, 4'd5);
    push_req(32'h4080_0000, 32'h4000_0000, 4'd6);
    @(posedge clk);
    #1;
    div_ready = 1'b0;
    fork
      begin
        run_op(4, 3, 32'h4080_0000, 5'b0, ok1);
        run_op(2, 1, 32'h4000_0000, 5'b0, ok2);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (rsp_valid === 1'b1 && rsp_ready === 1'b1) hs++;
          if (div_en === 1'b1 && div_ready === 1'b1) en_rdy++;
          if (div_en === 1'b1 && prev_en === 1'b0) begin
            rises++;
            if (rises == 2) second_rise = i;
          end
          if (div_ready === 1'b1 && rises == 1) last_rdy = i;
          prev_en = div_en;
        end
      end
    join
    rsp_ready = 1'b0;
    total++;
    if (!ok1 || !ok2) begin bad++; $display("FAIL sticky_issue: got ok=%b/%b want 1/1", ok1, ok2); end
    total++;
    if (hs != 2) begin bad++; $display("FAIL sticky_responses: got %0d want 2", hs); end
    total++;
    if (en_rdy != 2) begin bad++; $display("FAIL sticky_captures: got %0d want 2", en_rdy); end
    total++;
    if (second_rise - last_rdy != 3) begin
      bad++; $display("FAIL sticky_reissue_gap: got %0d want 3", second_rise - last_rdy);
    end
    total++;
    if (rsp_tag !== 4'd6 || rsp_latency !== 8'd2 || stat_count !== 32'd7 || stat_lat_sum !== 32'd28) begin
      bad++; $display("FAIL sticky_final: got tag=%0d lat=%0d stats=%0d/%0d want 6/2/7/28", rsp_tag, rsp_latency, stat_count, stat_lat_sum);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int en_cycles;
    push_req(32'h4000_0000, 32'h3F80_0000, 4'd7);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (div_en === 1'b1) begin ok = 1'b1; break; end
    end
    en_cycles = 1;
    for (int i = 0; i < 200 && ok; i++) begin
      @(negedge clk);
      if (div_en !== 1'b1) break;
      en_cycles++;
    end
    total++;
    if (!ok || en_cycles != 64) begin bad++; $display("FAIL timeout_en_cycles: got %0d want 64", en_cycles); end
    total++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || div_en !== 1'b0) begin
      bad++; $display("FAIL timeout_ctrl: got valid=%b to=%b en=%b want 1/1/0", rsp_valid, rsp_timeout, div_en);
    end
    total++;
    if (rsp_result !== 32'h7FC0_0000 || rsp_flag !== 5'b10000) begin
      bad++; $display("FAIL timeout_data: got %h/%b want 7fc00000/10000", rsp_result, rsp_flag);
    end
    total++;
    if (rsp_latency !== 8'd64 || rsp_tag !== 4'd7) begin
      bad++; $display("FAIL timeout_lat_tag: got %0d/%0d want 64/7", rsp_latency, rsp_tag);
    end
    total++;
    if (stat_count !== 32'd8 || stat_lat_sum !== 32'd92) begin
      bad++; $display("FAIL timeout_stats: got %0d/%0d want 8/92", stat_count, stat_lat_sum);
    end
    accept_rsp();
  endtask

  task automatic test_reset_mid_op();
    int en_seen;
    push_req(32'h4120_0000, 32'h4000_0000, 4'd8);
    push_req(32'h4140_0000, 32'h4000_0000, 4'd9);
    push_req(32'h4160_0000, 32'h4000_0000, 4'd10);
    repeat (5) @(negedge clk);
    total++;
    if (div_en !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL midrst_pre: got en=%b busy=%b want 1/1", div_en, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (div_en !== 1'b0 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs: got en=%b valid=%b want 0/0", div_en, rsp_valid);
    end
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_fifo: got ready=%b busy=%b want 1/0", req_ready, busy);
    end
    total++;
    if (stat_count !== 32'd0 || stat_lat_sum !== 32'd0) begin
      bad++; $display("FAIL midrst_stats: got %0d/%0d want 0/0", stat_count, stat_lat_sum);
    end
    en_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (div_en === 1'b1 || rsp_valid === 1'b1) en_seen++;
    end
    total++;
    if (en_seen != 0) begin bad++; $display("FAIL midrst_quiet: got %0d active cycles want 0", en_seen); end
  endtask

  task automatic test_flag_passthrough();
    int          lats [3] = '{5, 7, 12};
    logic [31:0] ress [3] = '{32'h7F80_0000, 32'h4040_0000, 32'h0080_0000};
    logic [4:0]  flgs [3] = '{5'b00100, 5'b00000, 5'b00010};
    bit ok;
    for (int k = 0; k < 3; k++) begin
      push_req(32'h3F80_0000 + 32'(k), 32'h0000_0000, 4'(11 + k));
      run_op(lats[k], 1, ress[k], flgs[k], ok);
      wait_rsp(50, ok);
      total++;
      if (!ok || rsp_result !== ress[k] || rsp_flag !== flgs[k]) begin
        bad++; $display("FAIL flag_data_%0d: got %h/%b want %h/%b", k, rsp_result, rsp_flag, ress[k], flgs[k]);
      end
      total++;
      if (rsp_latency !== 8'(lats[k]) || rsp_tag !== 4'(11 + k)) begin
        bad++; $display("FAIL flag_lat_tag_%0d: got %0d/%0d want %0d/%0d", k, rsp_latency, rsp_tag, lats[k], 11 + k);
      end
      accept_rsp();
    end
    @(negedge clk);
    total++;
    if (stat_count !== 32'd3 || stat_lat_sum !== 32'd24) begin
      bad++; $display("FAIL flag_stats: got %0d/%0d want 3/24", stat_count, stat_lat_sum);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_op1       = '0;
    req_op2       = '0;
    req_tag       = '0;
    div_ready     = 1'b0;
    div_result    = '0;
    div_flag      = '0;
    div_itr_count = '0;
    rsp_ready     = 1'b0;

    test_reset();
    test_single_op();
    test_backpressure();
    test_sticky_ready();
    test_timeout();
    test_reset_mid_op();
    test_flag_passthrough();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
